// File: rtl/data_mem.sv
// data_mem: single-port word-organised data memory with a three-state
// request/response handshake (IDLE -> BUSY -> RESP). The memory has
// 2^ADDR_W 32-bit words starting at byte address BASE. Every store is a
// byte-lane write, and every load returns the full word.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset (clears state, outputs, memory)
//   req    in   1   access request, sampled in IDLE and RESP
//   we     in   1   1 = store, 0 = load
//   addr   in   32  byte address
//   be     in   4   byte enables, lane-aligned to addr[1:0]
//   wdata  in   32  store data, already lane-aligned
//   ready  out  1   one-cycle completion strobe (high in RESP)
//   rdata  out  32  loaded word (0 for stores/errors), held until next completion
//   err    out  1   access rejected (misaligned/illegal be/out of range), held likewise
module data_mem #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               wr_en;

    logic [31:0]        mem_q [DEPTH];

    logic [31:0]        word_idx;
    logic [ADDR_W-1:0]  mem_idx;
    logic               in_range;
    logic               aligned;
    logic               ok;
    logic [31:0]        rd_word;

    // Decode the latched request: range check with 32-bit wrap, lane legality.
    always_comb begin
        word_idx = (addr_q - BASE) >> 2;
        mem_idx  = word_idx[ADDR_W-1:0];
        in_range = (addr_q >= BASE) && ((word_idx >> ADDR_W) == 32'd0);
        aligned  = 1'b0;
        case (be_q)
            4'b1111: aligned = (addr_q[1:0] == 2'b00);
            4'b0011: aligned = (addr_q[1:0] == 2'b00);
            4'b1100: aligned = (addr_q[1:0] == 2'b10);
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                     aligned = (be_q == (4'b0001 << addr_q[1:0]));
            default: aligned = 1'b0;
        endcase
        ok      = in_range && aligned;
        rd_word = mem_q[mem_idx];
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    be_d    = be;
                    wdata_d = wdata;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Access commits at the closing edge; results land with ready.
                state_d = RESP;
                ready_d = 1'b1;
                err_d   = !ok;
                rdata_d = (ok && !we_q) ? rd_word : 32'h0;
                wr_en   = ok && we_q;
            end
            RESP: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    be_d    = be;
                    wdata_d = wdata;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory array; reset clears every word and wins over a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a vector table of single accesses plus
// hand-written back-to-back, reset-in-BUSY, reset-with-req and BASE-wrap
// sequences. A second instance with BASE=0x100 shares all inputs.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready_a, err_a, ready_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] b_rd;
    logic        b_er;

    always #5 clk = ~clk;

    data_mem #(.ADDR_W(10), .BASE(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .ready(ready_a), .rdata(rdata_a), .err(err_a)
    );

    data_mem #(.ADDR_W(10), .BASE(32'h0000_0100)) dut_b (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .ready(ready_b), .rdata(rdata_b), .err(err_b)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One isolated access: req for one edge, inputs scrambled while BUSY.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] er, input logic ee,
                          input string nm);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; addr = 32'h0; be = 4'hF; wdata = 32'hFFFF_FFFF;
        check({nm, ".ready_busy"}, 32'(ready_a), 32'h0);
        @(posedge clk); #1;
        check({nm, ".ready_resp"}, 32'(ready_a), 32'h1);
        check({nm, ".rdata"}, rdata_a, er);
        check({nm, ".err"}, 32'(err_a), 32'(ee));
        b_rd = rdata_b; b_er = err_b;
        @(posedge clk); #1;
        check({nm, ".ready_after"}, 32'(ready_a), 32'h0);
        check({nm, ".rdata_hold"}, rdata_a, er);
        check({nm, ".err_hold"}, 32'(err_a), 32'(ee));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        bw [4];
        logic [31:0] ba [4];
        logic [31:0] bd [4];
        logic [31:0] bx [4];

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", 32'(ready_a), 32'h0);
        check("reset.rdata", rdata_a, 32'h0);
        check("reset.err", 32'(err_a), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-access table.
        vecs.push_back(mk(1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0022, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0020, 4'b0011, 32'h0000_BBCC, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h11AA_BBCC, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0021, 4'b0011, 32'h0000_FFFF, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h11AA_BBCC, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0000_0FFC, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0FFC, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_1000, 4'b1111, 32'h0,         32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0000_0013, 4'b1000, 32'h7700_0000, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h77AD_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0012, 4'b1100, 32'h5566_0000, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h5566_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0011, 4'b0001, 32'h0000_0099, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 4'b0110, 32'h0,         32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0,         32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h5566_BEEF, 1'b0));

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Back-to-back with req held: three stores then a load of the last word.
        bw[0] = 1'b1; ba[0] = 32'h40; bd[0] = 32'hA0A0_0001; bx[0] = 32'h0;
        bw[1] = 1'b1; ba[1] = 32'h44; bd[1] = 32'hB0B0_0002; bx[1] = 32'h0;
        bw[2] = 1'b1; ba[2] = 32'h48; bd[2] = 32'hC0C0_0003; bx[2] = 32'h0;
        bw[3] = 1'b0; ba[3] = 32'h48; bd[3] = 32'h0;         bx[3] = 32'hC0C0_0003;
        req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            we = bw[k]; addr = ba[k]; be = 4'b1111; wdata = bd[k];
            @(posedge clk); #1;
            check($sformatf("b2b%0d.ready_busy", k), 32'(ready_a), 32'h0);
            @(posedge clk); #1;
            check($sformatf("b2b%0d.ready_resp", k), 32'(ready_a), 32'h1);
            check($sformatf("b2b%0d.rdata", k), rdata_a, bx[k]);
            check($sformatf("b2b%0d.err", k), 32'(err_a), 32'h0);
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("b2b.ready_idle", 32'(ready_a), 32'h0);
        access(1'b0, 32'h40, 4'b1111, 32'h0, 32'hA0A0_0001, 1'b0, "b2b.rd40");
        access(1'b0, 32'h44, 4'b1111, 32'h0, 32'hB0B0_0002, 1'b0, "b2b.rd44");

        // Reset while BUSY: store aborted, no ready, outputs cleared.
        req = 1'b1; we = 1'b1; addr = 32'h60; be = 4'b1111; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_busy.ready", 32'(ready_a), 32'h0);
        check("rst_busy.rdata", rdata_a, 32'h0);
        check("rst_busy.err", 32'(err_a), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_busy.ready_post1", 32'(ready_a), 32'h0);
        @(posedge clk); #1;
        check("rst_busy.ready_post2", 32'(ready_a), 32'h0);
        access(1'b0, 32'h60, 4'b1111, 32'h0, 32'h0, 1'b0, "rst_busy.rd60");
        access(1'b0, 32'h10, 4'b1111, 32'h0, 32'h0, 1'b0, "rst_busy.rd10_cleared");

        // req coincident with reset is dropped.
        reset = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h64; be = 4'b1111; wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        reset = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        check("rst_req.ready1", 32'(ready_a), 32'h0);
        @(posedge clk); #1;
        check("rst_req.ready2", 32'(ready_a), 32'h0);
        access(1'b0, 32'h64, 4'b1111, 32'h0, 32'h0, 1'b0, "rst_req.rd64");

        // BASE=0x100 instance: wrap below BASE and upper range boundary.
        access(1'b0, 32'h0FC, 4'b1111, 32'h0, 32'h0, 1'b0, "wrap.a");
        check("wrap.b_err", 32'(b_er), 32'h1);
        check("wrap.b_rdata", b_rd, 32'h0);
        access(1'b0, 32'h100, 4'b1111, 32'h0, 32'h0, 1'b0, "base.a");
        check("base.b_err", 32'(b_er), 32'h0);
        access(1'b1, 32'h10FC, 4'b1111, 32'h0BAD_F00D, 32'h0, 1'b1, "btop_wr.a");
        check("btop_wr.b_err", 32'(b_er), 32'h0);
        access(1'b0, 32'h10FC, 4'b1111, 32'h0, 32'h0, 1'b1, "btop_rd.a");
        check("btop_rd.b_err", 32'(b_er), 32'h0);
        check("btop_rd.b_rdata", b_rd, 32'h0BAD_F00D);
        access(1'b0, 32'h1100, 4'b1111, 32'h0, 32'h0, 1'b1, "bover.a");
        check("bover.b_err", 32'(b_er), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
